// File: rtl/riscv_main_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, ALU and
// operand-select codes, FSM states and the per-state control word.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_REG_A  = 2'b10;

    localparam logic [1:0] SRCB_REG_B  = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;

    typedef enum logic [3:0] {
        ST_START, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB,
        ST_MEM_WRITE, ST_EXECUTE, ST_ALU_WB, ST_BRANCH, ST_HALT
    } state_t;

    // fetch / mem_write_st / retire are internal tags for the handshake-qualified outputs
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       mem_to_reg;
        logic       halted;
        logic       retire;
        logic       fetch;
        logic       mem_write_st;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.fetch     = 1'b1;
            end
            ST_DECODE: begin
                c.alu_src_a = SRCA_OLD_PC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = SRCA_REG_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_req      = 1'b1;
                c.mem_write    = 1'b1;
                c.iord         = 1'b1;
                c.mem_write_st = 1'b1;
            end
            ST_EXECUTE: begin
                c.alu_src_a = SRCA_REG_A;
                c.alu_src_b = SRCB_REG_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = SRCA_REG_A;
                c.alu_src_b     = SRCB_REG_B;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 1'b1;
                c.retire        = 1'b1;
            end
            ST_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_main_control_fsm_opcode_class.sv
// Combinational opcode classifier; anything outside the supported set is illegal.
module riscv_opcode_class
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_rtype,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       illegal
);

    // One-hot instruction class
    always_comb begin
        is_rtype  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE:  is_rtype  = 1'b1;
            OP_LOAD:   is_load   = 1'b1;
            OP_STORE:  is_store  = 1'b1;
            OP_BRANCH: is_branch = 1'b1;
            default:   illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_main_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and the memory req/ready handshake, and counts retirements.
module riscv_main_control_fsm
    import riscv_pkg::*;
#(
    parameter int RETIRE_W = 32
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                pc_src,
    output logic                mem_to_reg,
    output logic                instr_retired,
    output logic                halted,
    output logic [RETIRE_W-1:0] retire_count
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   load_pending;
    logic   is_rtype;
    logic   is_load;
    logic   is_store;
    logic   is_branch;
    logic   illegal;
    logic   unused_zero;

    // zero is gated with pc_write_cond in the datapath, not here
    assign unused_zero = zero;

    riscv_opcode_class u_opcode_class (
        .opcode    (opcode),
        .is_rtype  (is_rtype),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    // Next-state selection; a non-one-hot class vector is treated as illegal
    always_comb begin
        state_nxt = state;
        case (state)
            ST_START:     state_nxt = ST_FETCH;
            ST_FETCH:     if (mem_ready) state_nxt = ST_DECODE; else state_nxt = ST_FETCH;
            ST_DECODE: begin
                case ({is_rtype, is_load, is_store, is_branch, illegal})
                    5'b10000: state_nxt = ST_EXECUTE;
                    5'b01000: state_nxt = ST_MEM_ADDR;
                    5'b00100: state_nxt = ST_MEM_ADDR;
                    5'b00010: state_nxt = ST_BRANCH;
                    default:  state_nxt = ST_HALT;
                endcase
            end
            ST_MEM_ADDR:  if (load_pending) state_nxt = ST_MEM_READ; else state_nxt = ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_nxt = ST_MEM_WB; else state_nxt = ST_MEM_READ;
            ST_MEM_WB:    state_nxt = ST_FETCH;
            ST_MEM_WRITE: if (mem_ready) state_nxt = ST_FETCH; else state_nxt = ST_MEM_WRITE;
            ST_EXECUTE:   state_nxt = ST_ALU_WB;
            ST_ALU_WB:    state_nxt = ST_FETCH;
            ST_BRANCH:    state_nxt = ST_FETCH;
            ST_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_HALT;
        endcase
    end

    // State register, control word registered for the upcoming state, retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_START;
            ctrl         <= '0;
            load_pending <= 1'b0;
            retire_count <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt);
            if (state == ST_DECODE) begin
                load_pending <= is_load;
            end
            if (instr_retired) begin
                retire_count <= retire_count + RETIRE_W'(1);
            end
        end
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign halted        = ctrl.halted;
    assign ir_write      = ctrl.fetch & mem_ready;
    assign pc_write      = ctrl.fetch & mem_ready;
    assign instr_retired = ctrl.retire | (ctrl.mem_write_st & mem_ready);

endmodule

// File: tb/tb_riscv_main_control_fsm.sv
// Bench for riscv_main_control_fsm: constant vector table, directed multi-cycle
// sequences and randomized traffic against an instruction-step queue model.
module tb_riscv_main_control_fsm;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       mem_to_reg;
        logic       instr_retired;
        logic       halted;
    } obs_t;

    localparam obs_t V_ZERO  = obs_t'({8'b00000000, 2'b00, 2'b00, 2'b00, 4'b0000});
    localparam obs_t V_FETCH = obs_t'({8'b11001100, 2'b00, 2'b01, 2'b00, 4'b0000});
    localparam obs_t V_FWAIT = obs_t'({8'b11000000, 2'b00, 2'b01, 2'b00, 4'b0000});
    localparam obs_t V_DEC   = obs_t'({8'b00000000, 2'b01, 2'b10, 2'b00, 4'b0000});
    localparam obs_t V_MA    = obs_t'({8'b00000000, 2'b10, 2'b10, 2'b00, 4'b0000});
    localparam obs_t V_MRD   = obs_t'({8'b11010000, 2'b00, 2'b00, 2'b00, 4'b0000});
    localparam obs_t V_MWB   = obs_t'({8'b00000001, 2'b00, 2'b00, 2'b00, 4'b0110});
    localparam obs_t V_MWR   = obs_t'({8'b10110000, 2'b00, 2'b00, 2'b00, 4'b0010});
    localparam obs_t V_MWRW  = obs_t'({8'b10110000, 2'b00, 2'b00, 2'b00, 4'b0000});
    localparam obs_t V_EXE   = obs_t'({8'b00000000, 2'b10, 2'b00, 2'b10, 4'b0000});
    localparam obs_t V_AWB   = obs_t'({8'b00000001, 2'b00, 2'b00, 2'b00, 4'b0010});
    localparam obs_t V_BR    = obs_t'({8'b00000010, 2'b10, 2'b00, 2'b01, 4'b1010});

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic       z;
        obs_t       exp;
        int         cnt;
    } vec_t;

    typedef enum {P_START, P_FETCH, P_DEC, P_MA, P_MRD, P_MWB, P_MWR,
                  P_EXE, P_AWB, P_BR, P_HALT} ph_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic pc_src, mem_to_reg, instr_retired, halted;
    logic [31:0] retire_count;

    logic x_mem_req, x_mem_read, x_mem_write, x_iord, x_ir_write, x_pc_write;
    logic x_pc_write_cond, x_reg_write;
    logic [1:0] x_alu_src_a, x_alu_src_b, x_alu_op;
    logic x_pc_src, x_mem_to_reg, x_instr_retired, x_halted;
    logic [3:0] x_retire_count;

    obs_t o32, o4;
    int   checks = 0;
    int   errors = 0;

    ph_t         q[$];
    logic [6:0]  cur_op = OPC_R;
    logic [6:0]  next_op = OPC_R;
    int unsigned mcnt = 0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    riscv_main_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
        .instr_retired(instr_retired), .halted(halted), .retire_count(retire_count)
    );

    riscv_main_control_fsm #(.RETIRE_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(x_mem_req), .mem_read(x_mem_read), .mem_write(x_mem_write), .iord(x_iord),
        .ir_write(x_ir_write), .pc_write(x_pc_write), .pc_write_cond(x_pc_write_cond),
        .reg_write(x_reg_write), .alu_src_a(x_alu_src_a), .alu_src_b(x_alu_src_b),
        .alu_op(x_alu_op), .pc_src(x_pc_src), .mem_to_reg(x_mem_to_reg),
        .instr_retired(x_instr_retired), .halted(x_halted), .retire_count(x_retire_count)
    );

    assign o32 = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg,
                  instr_retired, halted};
    assign o4  = {x_mem_req, x_mem_read, x_mem_write, x_iord, x_ir_write, x_pc_write,
                  x_pc_write_cond, x_reg_write, x_alu_src_a, x_alu_src_b, x_alu_op,
                  x_pc_src, x_mem_to_reg, x_instr_retired, x_halted};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs for one step of an instruction
    function automatic obs_t exp_obs(input ph_t p, input logic rdy);
        obs_t e;
        e = '0;
        case (p)
            P_FETCH: begin
                e.mem_req = 1'b1; e.mem_read = 1'b1; e.src_b = 2'b01;
                e.ir_write = rdy; e.pc_write = rdy;
            end
            P_DEC:  begin e.src_a = 2'b01; e.src_b = 2'b10; end
            P_MA:   begin e.src_a = 2'b10; e.src_b = 2'b10; end
            P_MRD:  begin e.mem_req = 1'b1; e.mem_read = 1'b1; e.iord = 1'b1; end
            P_MWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_retired = 1'b1; end
            P_MWR:  begin
                e.mem_req = 1'b1; e.mem_write = 1'b1; e.iord = 1'b1; e.instr_retired = rdy;
            end
            P_EXE:  begin e.src_a = 2'b10; e.alu_op = 2'b10; end
            P_AWB:  begin e.reg_write = 1'b1; e.instr_retired = 1'b1; end
            P_BR:   begin
                e.src_a = 2'b10; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
                e.pc_src = 1'b1; e.instr_retired = 1'b1;
            end
            P_HALT: e.halted = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    // Advance the instruction-step queue across one clock edge
    task automatic model_clock(input logic rdy);
        obs_t e;
        logic waiting;
        e = exp_obs(q[0], rdy);
        waiting = (q[0] == P_FETCH || q[0] == P_MRD || q[0] == P_MWR) && !rdy;
        if (e.instr_retired) mcnt++;
        if (q[0] == P_HALT || waiting) return;
        if (q[0] == P_FETCH) begin
            void'(q.pop_front());
            cur_op = next_op;
            case (cur_op)
                OPC_R:   begin q.push_back(P_DEC); q.push_back(P_EXE); q.push_back(P_AWB); end
                OPC_LD:  begin q.push_back(P_DEC); q.push_back(P_MA);
                               q.push_back(P_MRD); q.push_back(P_MWB); end
                OPC_ST:  begin q.push_back(P_DEC); q.push_back(P_MA); q.push_back(P_MWR); end
                OPC_BEQ: begin q.push_back(P_DEC); q.push_back(P_BR); end
                default: begin q.push_back(P_DEC); q.push_back(P_HALT); end
            endcase
        end else begin
            void'(q.pop_front());
            if (q.size() == 0) q.push_back(P_FETCH);
        end
    endtask

    task automatic check_now(input string tag, input obs_t e);
        chk($sformatf("%s outputs", tag), o32, e);
        chk($sformatf("%s outputs w4", tag), o4, e);
        chk($sformatf("%s count", tag), retire_count, mcnt);
        chk($sformatf("%s count w4", tag), {28'd0, x_retire_count}, mcnt % 16);
    endtask

    task automatic step(input logic rdy, input logic z, input string tag, output logic ret);
        @(negedge clk);
        mem_ready = rdy;
        zero = z;
        opcode = (q[0] == P_FETCH || q[0] == P_START) ? 7'($urandom) : cur_op;
        #1;
        check_now(tag, exp_obs(q[0], rdy));
        ret = o32.instr_retired;
        @(posedge clk);
        model_clock(rdy);
    endtask

    task automatic run_instr(input logic [6:0] op, input int stalls, input logic z,
                             output int cycles);
        int   left;
        logic ret;
        left = stalls;
        cycles = 0;
        ret = 1'b0;
        next_op = op;
        while (!ret && cycles < 30) begin
            if ((q[0] == P_MRD || q[0] == P_MWR) && left > 0) begin
                left--;
                step(1'b0, z, "instr stall", ret);
            end else begin
                step(1'b1, z, "instr", ret);
            end
            cycles++;
        end
    endtask

    // Caller places this away from a clock edge; reset asserts immediately
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset outputs", o32, 32'd0);
        chk("reset outputs w4", o4, 32'd0);
        chk("reset count", retire_count, 32'd0);
        chk("reset count w4", {28'd0, x_retire_count}, 32'd0);
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("reset hold outputs", o32, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        q.push_back(P_START);
        mcnt = 0;
    endtask

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return OPC_BAD;
        if (r == 1) return 7'b0010011;
        case (r % 4)
            0:       return OPC_R;
            1:       return OPC_LD;
            2:       return OPC_ST;
            default: return OPC_BEQ;
        endcase
    endfunction

    task automatic add_vec(input logic [6:0] op, input logic rdy, input logic z,
                           input obs_t exp, input int cnt);
        vec_t v;
        v.op = op; v.rdy = rdy; v.z = z; v.exp = exp; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic r;
        int   cyc;
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
        q.push_back(P_START);

        add_vec(OPC_BAD, 1'b1, 1'b0, V_ZERO,  0);
        add_vec(OPC_BAD, 1'b1, 1'b0, V_FETCH, 0);
        add_vec(OPC_R,   1'b1, 1'b0, V_DEC,   0);
        add_vec(OPC_R,   1'b1, 1'b0, V_EXE,   0);
        add_vec(OPC_R,   1'b1, 1'b0, V_AWB,   0);
        add_vec(OPC_BAD, 1'b1, 1'b0, V_FETCH, 1);
        add_vec(OPC_BEQ, 1'b1, 1'b1, V_DEC,   1);
        add_vec(OPC_BEQ, 1'b1, 1'b1, V_BR,    1);
        add_vec(OPC_BAD, 1'b1, 1'b0, V_FETCH, 2);
        add_vec(OPC_ST,  1'b0, 1'b0, V_DEC,   2);
        add_vec(OPC_ST,  1'b1, 1'b0, V_MA,    2);
        add_vec(OPC_ST,  1'b0, 1'b0, V_MWRW,  2);
        add_vec(OPC_ST,  1'b1, 1'b0, V_MWR,   2);
        add_vec(OPC_BAD, 1'b0, 1'b0, V_FWAIT, 3);
        add_vec(OPC_BAD, 1'b1, 1'b0, V_FETCH, 3);
        add_vec(OPC_LD,  1'b1, 1'b0, V_DEC,   3);
        add_vec(OPC_LD,  1'b0, 1'b0, V_MA,    3);
        add_vec(OPC_LD,  1'b1, 1'b0, V_MRD,   3);
        add_vec(OPC_LD,  1'b1, 1'b0, V_MWB,   3);
        add_vec(OPC_BAD, 1'b1, 1'b0, V_FETCH, 4);

        @(negedge clk); #2; do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            opcode = tbl[i].op; mem_ready = tbl[i].rdy; zero = tbl[i].z;
            #1;
            chk($sformatf("vec%0d outputs", i), o32, tbl[i].exp);
            chk($sformatf("vec%0d count", i), retire_count, tbl[i].cnt);
        end

        // Latencies, load with three stall cycles, beq taken and not taken
        @(negedge clk); #2; do_reset();
        step(1'b1, 1'b0, "start", r);
        run_instr(OPC_LD, 3, 1'b0, cyc);  chk("load 3-stall latency", cyc, 8);
        run_instr(OPC_R, 0, 1'b0, cyc);   chk("rtype latency", cyc, 4);
        run_instr(OPC_ST, 0, 1'b0, cyc);  chk("store latency", cyc, 4);
        run_instr(OPC_ST, 2, 1'b0, cyc);  chk("store 2-stall latency", cyc, 6);
        run_instr(OPC_BEQ, 0, 1'b1, cyc); chk("beq taken latency", cyc, 3);
        run_instr(OPC_BEQ, 0, 1'b0, cyc); chk("beq not-taken latency", cyc, 3);
        #1; chk("count after six", retire_count, 32'd6);

        // Illegal opcode halts without retiring; reset clears halted
        @(negedge clk); #2; do_reset();
        step(1'b1, 1'b0, "start", r);
        next_op = OPC_BAD;
        step(1'b1, 1'b0, "bad fetch", r);
        step(1'b1, 1'b0, "bad decode", r);
        for (int k = 0; k < 5; k++) step(1'($urandom), 1'b0, "halt", r);
        chk("halt sticky", o32.halted, 32'd1);
        chk("halt no req", o32.mem_req, 32'd0);
        @(negedge clk); #2; do_reset();
        chk("halt cleared", o32.halted, 32'd0);
        step(1'b1, 1'b0, "post-halt start", r);

        // Reset in the middle of a stalled store
        @(negedge clk); #2; do_reset();
        step(1'b1, 1'b0, "start", r);
        next_op = OPC_ST;
        for (int k = 0; k < 6 && q[0] != P_MWR; k++) step(1'b1, 1'b0, "to mem_write", r);
        step(1'b0, 1'b0, "mem_write stall", r);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("in mem_write", o32.mem_write, 32'd1);
        #2; do_reset();
        step(1'b1, 1'b0, "abort start", r);
        step(1'b1, 1'b0, "abort fetch", r);

        // Narrow counter wraps after 16 retirements
        @(negedge clk); #2; do_reset();
        step(1'b1, 1'b0, "start", r);
        for (int k = 1; k <= 16; k++) begin
            run_instr(OPC_R, 0, 1'b0, cyc);
            #1;
            chk($sformatf("wrap count %0d", k), {28'd0, x_retire_count}, 32'(k % 16));
        end

        // Randomized traffic
        @(negedge clk); #2; do_reset();
        step(1'b1, 1'b0, "rnd start", r);
        for (int c = 0; c < 2000; c++) begin
            if (q[0] == P_HALT) begin
                step(1'($urandom), 1'b0, "rnd halt", r);
                @(negedge clk); #2; do_reset();
                step(1'b1, 1'b0, "rnd start", r);
            end else begin
                if (q[0] == P_FETCH) next_op = pick_op();
                step(($urandom_range(0, 3) != 0), 1'($urandom), "rnd", r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
